// File: rtl/pwm_multiphase.sv
// ---------------------------------------------------------------------------
// pwm_multiphase
//
// Interleaved multi-phase half-bridge PWM generator with deadtime insertion.
// A master counter runs 0..tick_count_period-1. Each channel sees its own
// counter, offset by an equal share of the period, so the phases are spread
// evenly. Per-channel duty values are captured into shadow registers on
// load_input_values. They become active only when the master counter is 0,
// so a period is never altered part-way through.
//
// Ports
//   clock                sole clock, rising edge
//   reset                synchronous, active-high
//   enable               level; 0 forces all gate outputs low
//   tick_count_highside  per-channel highside on-time, channel i at
//                        [i*bitwidth +: bitwidth]
//   load_input_values    one-cycle strobe capturing tick_count_highside
//   period_start         one-cycle pulse following master counter == 0
//   calculation_error    sticky flag: a load contained a duty > period
//   highside_output      registered highside gate per channel
//   lowside_output       registered lowside gate per channel
// ---------------------------------------------------------------------------
module pwm_multiphase #(
    parameter int channel_count          = 3,
    parameter int tick_count_period      = 100,
    parameter int bitwidth               = $clog2(tick_count_period + 1),
    parameter int deadtime_hs_to_ls      = 5,
    parameter int deadtime_ls_to_hs      = 5,
    parameter int minimum_driver_on_time = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [channel_count*bitwidth-1:0] tick_count_highside,
    input  logic                              load_input_values,
    output logic                              period_start,
    output logic                              calculation_error,
    output logic [channel_count-1:0]          highside_output,
    output logic [channel_count-1:0]          lowside_output
);

    // One extra bit so master + offset (up to 2*period-2) cannot overflow.
    localparam int CW         = bitwidth + 1;
    localparam int FLAT_TOP_T = tick_count_period - deadtime_hs_to_ls
                                - deadtime_ls_to_hs - minimum_driver_on_time;
    localparam int GUARD_MAX  = (deadtime_hs_to_ls > deadtime_ls_to_hs) ?
                                deadtime_hs_to_ls : deadtime_ls_to_hs;
    localparam int GW         = (GUARD_MAX < 1) ? 1 : $clog2(GUARD_MAX + 1);

    localparam logic [bitwidth-1:0] MASTER_LAST = bitwidth'(tick_count_period - 1);
    localparam logic [CW-1:0]       PERIOD_C    = CW'(tick_count_period);
    localparam logic [CW-1:0]       MIN_ON_C    = CW'(minimum_driver_on_time);
    localparam logic [CW-1:0]       FLAT_TOP_C  = CW'(FLAT_TOP_T);
    localparam logic [CW-1:0]       DHL_C       = CW'(deadtime_hs_to_ls);
    localparam logic [CW-1:0]       LS_END_C    = CW'(tick_count_period - deadtime_ls_to_hs);
    localparam logic [GW-1:0]       GUARD_HL    = GW'(deadtime_hs_to_ls);
    localparam logic [GW-1:0]       GUARD_LH    = GW'(deadtime_ls_to_hs);
    localparam logic [GW-1:0]       GUARD_SAT   = GW'(GUARD_MAX);

    logic [bitwidth-1:0] master_q, master_d;
    logic                at_wrap;
    logic                period_start_q;
    logic                error_q, error_d;
    logic                load_bad;
    logic                drive_ok;
    logic [bitwidth-1:0] shadow_q [channel_count];
    logic [bitwidth-1:0] shadow_d [channel_count];
    logic [bitwidth-1:0] active_q [channel_count];
    logic [bitwidth-1:0] duty_eff [channel_count];

    always_comb begin
        master_d = (master_q == MASTER_LAST) ? '0 : master_q + 1'b1;
        at_wrap  = (master_q == '0);
        load_bad = 1'b0;
        for (int i = 0; i < channel_count; i++) begin
            if ({1'b0, tick_count_highside[i*bitwidth +: bitwidth]} > PERIOD_C) begin
                load_bad = 1'b1;
            end
        end
        error_d  = error_q | (load_input_values & load_bad);
        drive_ok = enable & ~error_q;
        for (int i = 0; i < channel_count; i++) begin
            // A load containing any out-of-range duty is discarded as a whole.
            shadow_d[i] = (load_input_values && !load_bad) ?
                          tick_count_highside[i*bitwidth +: bitwidth] : shadow_q[i];
            // In the wrap cycle the channels already work from the newly
            // committed duty, so a new value governs the whole next period.
            duty_eff[i] = at_wrap ? shadow_q[i] : active_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            master_q       <= '0;
            period_start_q <= 1'b0;
            error_q        <= 1'b0;
            for (int i = 0; i < channel_count; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            master_q       <= master_d;
            period_start_q <= at_wrap;
            error_q        <= error_d;
            for (int i = 0; i < channel_count; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= duty_eff[i];
            end
        end
    end

    assign period_start      = period_start_q;
    assign calculation_error = error_q;

    for (genvar ch = 0; ch < channel_count; ch++) begin : g_chan
        localparam int OFFSET = (ch * tick_count_period) / channel_count;

        logic [CW-1:0] sum, cnt, duty;
        logic          hs_req, ls_req;
        logic          hs_d, ls_d, hs_q, ls_q;
        // Cycles each gate has been low, saturating; a gate may only rise
        // once the opposite gate has been low for its deadtime.
        logic [GW-1:0] hs_low_q, hs_low_d, ls_low_q, ls_low_d;

        always_comb begin
            sum    = {1'b0, master_q} + CW'(OFFSET);
            cnt    = (sum >= PERIOD_C) ? sum - PERIOD_C : sum;
            duty   = {1'b0, duty_eff[ch]};
            hs_req = 1'b0;
            ls_req = 1'b0;
            if (duty < MIN_ON_C) begin
                ls_req = 1'b1;
            end else if (duty > FLAT_TOP_C) begin
                hs_req = 1'b1;
            end else begin
                hs_req = (cnt < duty);
                ls_req = (cnt >= duty + DHL_C) && (cnt < LS_END_C);
            end
            hs_d = drive_ok & hs_req & (ls_low_q >= GUARD_LH);
            ls_d = drive_ok & ls_req & (hs_low_q >= GUARD_HL) & ~hs_d;
            hs_low_d = hs_d ? '0 :
                       ((hs_low_q == GUARD_SAT) ? hs_low_q : hs_low_q + 1'b1);
            ls_low_d = ls_d ? '0 :
                       ((ls_low_q == GUARD_SAT) ? ls_low_q : ls_low_q + 1'b1);
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                hs_q     <= 1'b0;
                ls_q     <= 1'b0;
                hs_low_q <= GUARD_SAT;
                ls_low_q <= GUARD_SAT;
            end else begin
                hs_q     <= hs_d;
                ls_q     <= ls_d;
                hs_low_q <= hs_low_d;
                ls_low_q <= ls_low_d;
            end
        end

        assign highside_output[ch] = hs_q;
        // Final interlock: lowside can never be shown together with highside.
        assign lowside_output[ch]  = ls_q & ~hs_q;
    end

endmodule

// File: tb/tb_pwm_multiphase.sv
// ---------------------------------------------------------------------------
// tb_pwm_multiphase
//
// Scoreboard bench for pwm_multiphase with default parameters (3 channels,
// period 100, deadtimes 5/5, minimum on-time 8). The stimulus process pushes
// hand-computed expected gate patterns, tagged with the clock cycle at which
// they must appear; a monitor on the falling edge pops and compares them.
// Timing model: t counts rising edges since reset release; at the falling edge
// with index t the master counter holds t mod 100, and the gates show the
// decision taken for master value t-1.
// ---------------------------------------------------------------------------
module tb_pwm_multiphase;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [20:0] tick_count_highside;
    logic        load_input_values;
    logic        period_start;
    logic        calculation_error;
    logic [2:0]  highside_output;
    logic [2:0]  lowside_output;

    pwm_multiphase dut (
        .clock               (clock),
        .reset               (reset),
        .enable              (enable),
        .tick_count_highside (tick_count_highside),
        .load_input_values   (load_input_values),
        .period_start        (period_start),
        .calculation_error   (calculation_error),
        .highside_output     (highside_output),
        .lowside_output      (lowside_output)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int        at;
        logic [2:0] hs;
        logic [2:0] ls;
        logic [2:0] mask;
        logic       err;
        logic       ps;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   rel         = 0;

    function automatic logic [20:0] pack3(input int d0, input int d1, input int d2);
        logic [6:0] a, b, c;
        a = 7'(d0);
        b = 7'(d1);
        c = 7'(d2);
        return {c, b, a};
    endfunction

    task automatic expect_at(input int t, input logic [2:0] h, input logic [2:0] l,
                             input logic [2:0] m, input logic e, input logic p,
                             input string n);
        exp_t x;
        int   k;
        x.at = rel + t; x.hs = h; x.ls = l; x.mask = m; x.err = e; x.ps = p; x.name = n;
        k = sb.size();
        while (k > 0 && sb[k-1].at > x.at) k--;
        sb.insert(k, x);
    endtask

    task automatic wait_t(input int t);
        int g;
        g = 0;
        while (cyc < rel + t && g < 5000) begin
            @(negedge clock);
            g++;
        end
        if (cyc != rel + t) begin
            miscompares++;
            $display("FAIL wait_t target=%0d actual cyc=%0d required cyc=%0d", t, cyc, rel + t);
        end
    endtask

    task automatic load(input logic [20:0] v);
        tick_count_highside = v;
        load_input_values   = 1'b1;
        @(negedge clock);
        load_input_values   = 1'b0;
    endtask

    // Monitor: interlock on every cycle, scoreboard entries when due.
    always @(negedge clock) begin
        exp_t e;
        if ((highside_output & lowside_output) != 3'b000) begin
            miscompares++;
            $display("FAIL interlock cyc=%0d actual hs=%b ls=%b required no overlap",
                     cyc, highside_output, lowside_output);
        end
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if (e.at < cyc) begin
                miscompares++;
                $display("FAIL %s missed: actual cyc=%0d required cyc=%0d", e.name, cyc, e.at);
            end else if (((highside_output & e.mask) != (e.hs & e.mask)) ||
                         ((lowside_output & e.mask) != (e.ls & e.mask)) ||
                         (calculation_error != e.err) || (period_start != e.ps)) begin
                miscompares++;
                $display("FAIL %s cyc=%0d actual hs=%b ls=%b err=%b ps=%b required hs=%b ls=%b err=%b ps=%b mask=%b",
                         e.name, cyc, highside_output, lowside_output, calculation_error,
                         period_start, e.hs, e.ls, e.err, e.ps, e.mask);
            end
        end
    end

    initial begin
        int g;
        reset               = 1'b1;
        enable              = 1'b0;
        load_input_values   = 1'b0;
        tick_count_highside = '0;
        repeat (3) @(negedge clock);
        rel = cyc;
        expect_at(1, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, "reset_state_a");
        expect_at(2, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, "reset_state_b");
        wait_t(2);

        // Release; duty 0 is flat-bottom on every channel.
        reset  = 1'b0;
        enable = 1'b1;
        rel    = cyc;
        expect_at(1,   3'b000, 3'b111, 3'b111, 1'b0, 1'b1, "release_flat_bottom");
        expect_at(50,  3'b000, 3'b111, 3'b111, 1'b0, 1'b0, "flat_bottom_mid");
        // ch0 leaves flat-bottom at the wrap: ls falls, hs waits out the guard.
        expect_at(100, 3'b000, 3'b001, 3'b001, 1'b0, 1'b0, "fb_to_40_last_ls");
        expect_at(101, 3'b000, 3'b000, 3'b001, 1'b0, 1'b1, "fb_to_40_ls_fall");
        expect_at(105, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, "fb_to_40_guard");
        expect_at(106, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0, "fb_to_40_hs_rise");
        expect_at(140, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0, "fb_to_40_hs_last");
        expect_at(141, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, "fb_to_40_hs_fall");
        // Steady d=40, offsets 0/33/66.
        expect_at(201, 3'b011, 3'b100, 3'b111, 1'b0, 1'b1, "d40_s1");
        expect_at(240, 3'b101, 3'b010, 3'b111, 1'b0, 1'b0, "d40_s40");
        expect_at(241, 3'b100, 3'b010, 3'b111, 1'b0, 1'b0, "d40_s41");
        expect_at(246, 3'b100, 3'b011, 3'b111, 1'b0, 1'b0, "d40_s46");
        expect_at(268, 3'b110, 3'b001, 3'b111, 1'b0, 1'b0, "d40_s68");
        expect_at(296, 3'b010, 3'b100, 3'b111, 1'b0, 1'b0, "d40_s96");
        // Mid-period loads must not disturb the running period.
        expect_at(355, 3'b100, 3'b011, 3'b111, 1'b0, 1'b0, "hold40_s55");
        expect_at(399, 3'b010, 3'b100, 3'b111, 1'b0, 1'b0, "hold40_s99");
        expect_at(401, 3'b001, 3'b000, 3'b001, 1'b0, 1'b1, "d60_ch0_s1");
        expect_at(455, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0, "d60_ch0_s55");
        expect_at(460, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0, "d60_ch0_s60");
        expect_at(461, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, "d60_ch0_s61");
        expect_at(466, 3'b000, 3'b001, 3'b001, 1'b0, 1'b0, "d60_ch0_s66");
        expect_at(561, 3'b100, 3'b010, 3'b111, 1'b0, 1'b0, "d60_s61");
        expect_at(566, 3'b100, 3'b001, 3'b111, 1'b0, 1'b0, "d60_s66");
        // ch0=3 flat-bottom, ch1=95 flat-top, ch2=82 regular at the threshold.
        expect_at(716, 3'b110, 3'b001, 3'b111, 1'b0, 1'b0, "mix_s16");
        expect_at(717, 3'b010, 3'b001, 3'b111, 1'b0, 1'b0, "mix_s17");
        expect_at(725, 3'b010, 3'b101, 3'b111, 1'b0, 1'b0, "mix_s25");
        expect_at(730, 3'b010, 3'b001, 3'b111, 1'b0, 1'b0, "mix_s30");
        expect_at(751, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, "midreset_a");
        expect_at(752, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, "midreset_b");

        load(pack3(40, 40, 40));
        wait_t(310);
        load(pack3(40, 40, 40));
        wait_t(320);
        load(pack3(50, 50, 50));
        wait_t(350);
        load(pack3(60, 60, 60));
        wait_t(570);
        load(pack3(3, 95, 82));

        // Reset at master 50 while ch1 highside is on.
        wait_t(750);
        reset = 1'b1;
        wait_t(752);
        reset = 1'b0;
        rel   = cyc;
        expect_at(1,  3'b000, 3'b111, 3'b111, 1'b0, 1'b1, "after_reset_ps");
        expect_at(2,  3'b000, 3'b111, 3'b111, 1'b0, 1'b0, "after_reset_b");
        expect_at(21, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, "disable_a");
        expect_at(25, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, "disable_b");
        expect_at(31, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0, "reenable");
        expect_at(41, 3'b000, 3'b111, 3'b111, 1'b1, 1'b0, "error_flag");
        expect_at(42, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0, "error_outputs_off");
        expect_at(90, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0, "error_held");
        expect_at(96, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, "error_cleared");
        wait_t(20);
        enable = 1'b0;
        wait_t(30);
        enable = 1'b1;
        wait_t(40);
        load(pack3(40, 120, 40));
        wait_t(95);
        reset = 1'b1;
        wait_t(97);
        reset = 1'b0;

        g = 0;
        while (sb.size() > 0 && g < 200) begin
            @(negedge clock);
            g++;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain actual pending=%0d required pending=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_multiphase.md
PWM_MULTIPHASE -- requirements
Module: pwm_multiphase

Interface
REQ-001 SHALL have parameter channel_count, default 3, number of interleaved half-bridge phases (1..8).
REQ-002 SHALL have parameter tick_count_period, default 100, PWM period in clock ticks.
REQ-003 SHALL have parameter bitwidth, default $clog2(tick_count_period+1), width of tick and duty values.
REQ-004 SHALL have parameter deadtime_hs_to_ls, default 5, ticks between highside fall and lowside rise.
REQ-005 SHALL have parameter deadtime_ls_to_hs, default 5, ticks between lowside fall and highside rise.
REQ-006 SHALL have parameter minimum_driver_on_time, default 8, shortest gate pulse in ticks.
REQ-007 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port enable  input  1  level; 0 forces all gate outputs low.
REQ-010 SHALL have port tick_count_highside  input  channel_count*bitwidth  per-channel highside on-time; channel i at bits [i*bitwidth +: bitwidth].
REQ-011 SHALL have port load_input_values  input  1  single-cycle strobe capturing all tick_count_highside values into shadow registers.
REQ-012 SHALL have port period_start  output  1  high for one cycle when the master counter equals 0.
REQ-013 SHALL have port calculation_error  output  1  latched invalid-duty flag.
REQ-014 SHALL have port highside_output, lowside_output  output  channel_count each  registered gate signals, bit i = channel i.

Function
REQ-015 SHALL run a master counter 0..tick_count_period-1, incrementing every cycle and wrapping to 0.
REQ-016 SHALL derive channel counter c_i = (master + floor(i*tick_count_period/channel_count)) mod tick_count_period.
REQ-017 SHALL, on load_input_values, copy inputs to shadow registers; shadow SHALL commit to active registers only in the cycle the master counter is 0; loads arriving mid-period never alter the current period.
REQ-018 SHALL let a later strobe in the same period overwrite shadow; the last strobe before wrap wins.
REQ-019 SHALL classify each channel from its active duty d; threshold T = tick_count_period - deadtime_hs_to_ls - deadtime_ls_to_hs - minimum_driver_on_time.
REQ-020 SHALL treat d < minimum_driver_on_time as flat-bottom: highside 0, lowside requested continuously.
REQ-021 SHALL treat d > T (and d <= tick_count_period) as flat-top: lowside 0, highside requested continuously.
REQ-022 SHALL otherwise request highside for c_i in [0, d) and lowside for c_i in [d+deadtime_hs_to_ls, tick_count_period-deadtime_ls_to_hs).
REQ-023 SHALL keep per-channel deadtime guard counters: highside may rise only after lowside low >= deadtime_ls_to_hs cycles; lowside only after highside low >= deadtime_hs_to_ls cycles; a blocked request rises once the guard expires if still requested.
REQ-024 SHALL register outputs: output change appears one cycle after the channel-counter value that causes it.
REQ-025 SHALL set calculation_error the cycle after a load where any d > tick_count_period; that load SHALL NOT enter shadow.
REQ-026 SHALL, while calculation_error=1 or enable=0, drive all outputs 0 from the next cycle and keep guard counters running.
REQ-027 SHALL never assert highside_output[i] and lowside_output[i] together; lowside SHALL be gated by ~highside as final interlock.

Reset
REQ-028 SHALL on reset clear master counter, shadow and active duties to 0, guard counters to expired, calculation_error to 0, all outputs to 0, period_start to 0.
REQ-029 SHALL honour reset mid-period immediately at the next edge; calculation_error clears only by reset.

Verification (channel_count=3, period=100, deadtimes 5/5, min 8, T=82)
REQ-030 Load d=40 all, enable=1 -> ch0 hs high c_0 0..39, ls 45..94; ch1 offset 33, ch2 offset 66; never both high.
REQ-031 Load 40 at master=10, then 60 at master=50 -> 40 holds to period end; 60 takes effect at master=0.
REQ-032 d=3 -> ch lowside constant 1, hs 0; d=95 -> hs constant 1, ls 0; d=82 -> regular, ls 87..94.
REQ-033 Flat-bottom (d=3) to d=40 at wrap -> ls falls at c=0, hs rises at c=5 (guard), falls after c=39.
REQ-034 Load d=120 on ch1 -> calculation_error=1 next cycle, all outputs 0, held until reset pulse.
REQ-035 Reset at master=50 during hs pulse -> next cycle all outputs 0, counter 0, period_start after release.
